// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request encoder.
//   state_t          : encoder FSM states
//   NUM_REQ, CODE_W  : request line count and code width
//   map_line_to_code : request line index k -> code 7-k
package irq_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned CODE_W  = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      RETIRE  = 2'd2
   } state_t;

   // Line k maps to code 7-k; for 3 bits that is just the bitwise inverse.
   function automatic logic [CODE_W-1:0] map_line_to_code(input logic [CODE_W-1:0] k);
      return ~k;
   endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder, highest set index wins.
//   vec    : input bit vector
//   code_c : index of the highest set bit (0 when vec is zero)
//   nz_c   : high when any bit of vec is set
module prio_enc8
   import irq_pkg::*;
(
   input  logic [NUM_REQ-1:0] vec,
   output logic [CODE_W-1:0]  code_c,
   output logic               nz_c
);

   // Ascending scan: the last set bit seen is the highest one.
   always_comb begin
      code_c = '0;
      nz_c   = |vec;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (vec[i]) code_c = CODE_W'(i);
      end
   end

endmodule

// File: rtl/irq_encoder8.sv
// Sequential 8-to-3 interrupt priority encoder with valid/ack handshake.
// Falling edges on active-low request lines are captured into a pending
// register (line k -> code 7-k); the highest pending code is presented.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_n       : asynchronous active-low request lines
//   en_n        : active-low capture enable
//   ack         : consumer acknowledge of the presented code
//   code, valid : presented code and its valid flag
//   pending     : pending flags indexed by code
//   any_pend_n  : low when any code is pending
//   ovf         : one-cycle pulse when an edge hits an already-pending code
module irq_encoder8
   import irq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2   // must be >= 2
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_n,
   input  logic               en_n,
   input  logic               ack,
   output logic [CODE_W-1:0]  code,
   output logic               valid,
   output logic [NUM_REQ-1:0] pending,
   output logic               any_pend_n,
   output logic               ovf
);

   logic [NUM_REQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_REQ-1:0] prev_q;
   logic [NUM_REQ-1:0] fall_c;
   logic [NUM_REQ-1:0] set_c;
   logic [NUM_REQ-1:0] clr_c;
   logic [NUM_REQ-1:0] pending_d;
   logic               ovf_d;
   logic [CODE_W-1:0]  enc_code_c;
   logic               enc_nz_c;
   state_t             state_q, state_d;
   logic [CODE_W-1:0]  code_d;
   logic               valid_d;

   // Synchronizer chain plus one delayed sample for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
         prev_q <= '1;
      end else begin
         sync_q[0] <= req_n;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign fall_c = prev_q & ~sync_q[SYNC_STAGES-1];

   // Captures are reordered into code space; en_n gates new captures only.
   always_comb begin
      set_c = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         set_c[map_line_to_code(CODE_W'(k))] = fall_c[k] & ~en_n;
      end
   end

   // Retire the presented code on ack; a coincident set wins over the clear.
   always_comb begin
      clr_c = '0;
      if (state_q == PRESENT && ack) clr_c[code] = 1'b1;
   end

   assign pending_d = (pending & ~clr_c) | set_c;
   assign ovf_d     = |(set_c & pending & ~clr_c);

   prio_enc8 u_enc (
      .vec    (pending),
      .code_c (enc_code_c),
      .nz_c   (enc_nz_c)
   );

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      code_d  = code;
      valid_d = valid;
      case (state_q)
         IDLE: begin
            if (enc_nz_c) begin
               code_d  = enc_code_c;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (ack) begin
               valid_d = 1'b0;
               state_d = RETIRE;
            end
         end
         RETIRE: begin
            state_d = IDLE;
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         code    <= '0;
         valid   <= 1'b0;
         pending <= '0;
         ovf     <= 1'b0;
      end else begin
         state_q <= state_d;
         code    <= code_d;
         valid   <= valid_d;
         pending <= pending_d;
         ovf     <= ovf_d;
      end
   end

   assign any_pend_n = ~|pending;

endmodule

// File: tb/tb_irq_encoder8.sv
// Directed table-driven bench for irq_encoder8: one vector per clock cycle.
module tb_irq_encoder8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_n;
   logic       en_n;
   logic       ack;
   logic [2:0] code;
   logic       valid;
   logic [7:0] pending;
   logic       any_pend_n;
   logic       ovf;

   int passed = 0;
   int total  = 0;

   irq_encoder8 #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_n      (req_n),
      .en_n       (en_n),
      .ack        (ack),
      .code       (code),
      .valid      (valid),
      .pending    (pending),
      .any_pend_n (any_pend_n),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      grp;
      logic [7:0] req_n;
      logic       en_n;
      logic       ack;
      logic       exp_valid;
      logic [2:0] exp_code;
      logic [7:0] exp_pend;
      logic       exp_ovf;
   } vec_t;

   vec_t  vecs[$];
   string cur_grp;

   task automatic v(input logic [7:0] r, input logic e, input logic a,
                    input logic ev, input logic [2:0] ec, input logic [7:0] ep,
                    input logic eo);
      vec_t t;
      t.grp = cur_grp; t.req_n = r; t.en_n = e; t.ack = a;
      t.exp_valid = ev; t.exp_code = ec; t.exp_pend = ep; t.exp_ovf = eo;
      vecs.push_back(t);
   endtask

   task automatic flush();
      for (int i = 0; i < 3; i++) v(8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
   endtask

   task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s[%0d] got %0h want %0h", nm, idx, got, want);
   endtask

   task automatic chk_all(input string g, input int idx, input logic ev, input logic [2:0] ec,
                          input logic [7:0] ep, input logic eo);
      chk({g, ".valid"}, idx, 8'(valid), 8'(ev));
      chk({g, ".pending"}, idx, pending, ep);
      chk({g, ".any_pend_n"}, idx, 8'(any_pend_n), 8'(ep == 8'h00));
      chk({g, ".ovf"}, idx, 8'(ovf), 8'(eo));
      if (ev) chk({g, ".code"}, idx, 8'(code), 8'(ec));
   endtask

   initial begin
      // ---- vector table ----
      cur_grp = "idle";
      for (int i = 0; i < 4; i++) v(8'hFF, 0, 0, 0, 0, 8'h00, 0);

      cur_grp = "single";
      v(8'hFE, 0, 0, 0, 0, 8'h00, 0);
      v(8'hFE, 0, 0, 0, 0, 8'h00, 0);
      v(8'hFE, 0, 0, 0, 0, 8'h80, 0);
      v(8'hFE, 0, 0, 1, 7, 8'h80, 0);
      v(8'hFE, 0, 1, 0, 0, 8'h00, 0);
      v(8'hFE, 0, 0, 0, 0, 8'h00, 0);
      v(8'hFE, 0, 0, 0, 0, 8'h00, 0);
      flush();

      cur_grp = "prio";
      v(8'h7B, 0, 1, 0, 0, 8'h00, 0);
      v(8'h7B, 0, 1, 0, 0, 8'h00, 0);
      v(8'h7B, 0, 1, 0, 0, 8'h21, 0);
      v(8'h7B, 0, 1, 1, 5, 8'h21, 0);
      v(8'h7B, 0, 1, 0, 0, 8'h01, 0);
      v(8'h7B, 0, 1, 0, 0, 8'h01, 0);
      v(8'h7B, 0, 1, 1, 0, 8'h01, 0);
      v(8'h7B, 0, 1, 0, 0, 8'h00, 0);
      v(8'h7B, 0, 1, 0, 0, 8'h00, 0);
      flush();

      cur_grp = "nopre";
      v(8'hDF, 0, 0, 0, 0, 8'h00, 0);
      v(8'hDF, 0, 0, 0, 0, 8'h00, 0);
      v(8'hDF, 0, 0, 0, 0, 8'h04, 0);
      v(8'hDF, 0, 0, 1, 2, 8'h04, 0);
      v(8'hDE, 0, 0, 1, 2, 8'h04, 0);
      v(8'hDE, 0, 0, 1, 2, 8'h04, 0);
      v(8'hDE, 0, 0, 1, 2, 8'h84, 0);
      v(8'hDE, 0, 0, 1, 2, 8'h84, 0);
      v(8'hDE, 0, 1, 0, 0, 8'h80, 0);
      v(8'hDE, 0, 0, 0, 0, 8'h80, 0);
      v(8'hDE, 0, 0, 1, 7, 8'h80, 0);
      v(8'hDE, 0, 1, 0, 0, 8'h00, 0);
      v(8'hDE, 0, 0, 0, 0, 8'h00, 0);
      flush();

      cur_grp = "ovf";
      v(8'hF7, 0, 0, 0, 0, 8'h00, 0);
      v(8'hF7, 0, 0, 0, 0, 8'h00, 0);
      v(8'hF7, 0, 0, 0, 0, 8'h10, 0);
      v(8'hF7, 0, 0, 1, 4, 8'h10, 0);
      v(8'hFF, 0, 0, 1, 4, 8'h10, 0);
      v(8'hFF, 0, 0, 1, 4, 8'h10, 0);
      v(8'hF7, 0, 0, 1, 4, 8'h10, 0);
      v(8'hF7, 0, 0, 1, 4, 8'h10, 0);
      v(8'hF7, 0, 0, 1, 4, 8'h10, 1);
      v(8'hF7, 0, 0, 1, 4, 8'h10, 0);
      v(8'hF7, 0, 1, 0, 0, 8'h00, 0);
      v(8'hF7, 0, 0, 0, 0, 8'h00, 0);
      v(8'hF7, 0, 0, 0, 0, 8'h00, 0);
      v(8'hF7, 0, 0, 0, 0, 8'h00, 0);
      flush();

      cur_grp = "merge";
      v(8'hF7, 0, 0, 0, 0, 8'h00, 0);
      v(8'hF7, 0, 0, 0, 0, 8'h00, 0);
      v(8'hF7, 0, 0, 0, 0, 8'h10, 0);
      v(8'hF7, 0, 0, 1, 4, 8'h10, 0);
      v(8'hFF, 0, 0, 1, 4, 8'h10, 0);
      v(8'hFF, 0, 0, 1, 4, 8'h10, 0);
      v(8'hF7, 0, 0, 1, 4, 8'h10, 0);
      v(8'hF7, 0, 0, 1, 4, 8'h10, 0);
      v(8'hF7, 0, 1, 0, 0, 8'h10, 0);
      v(8'hF7, 0, 0, 0, 0, 8'h10, 0);
      v(8'hF7, 0, 0, 1, 4, 8'h10, 0);
      v(8'hF7, 0, 1, 0, 0, 8'h00, 0);
      v(8'hF7, 0, 0, 0, 0, 8'h00, 0);
      flush();

      cur_grp = "enable";
      for (int i = 0; i < 4; i++) v(8'h00, 1, 0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 3; i++) v(8'hFF, 1, 0, 0, 0, 8'h00, 0);

      cur_grp = "rst";
      v(8'hFD, 0, 0, 0, 0, 8'h00, 0);
      v(8'hFD, 0, 0, 0, 0, 8'h00, 0);
      v(8'hFD, 0, 0, 0, 0, 8'h40, 0);
      v(8'hFD, 0, 0, 1, 6, 8'h40, 0);

      // ---- reset state ----
      rst_n = 1'b0; req_n = 8'hFF; en_n = 1'b0; ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 0, 1'b0, 3'd0, 8'h00, 1'b0);
      chk("reset.code", 0, 8'(code), 8'h00);
      rst_n = 1'b1;

      // ---- table ----
      foreach (vecs[i]) begin
         req_n = vecs[i].req_n;
         en_n  = vecs[i].en_n;
         ack   = vecs[i].ack;
         @(posedge clk);
         #1;
         chk_all(vecs[i].grp, i, vecs[i].exp_valid, vecs[i].exp_code,
                 vecs[i].exp_pend, vecs[i].exp_ovf);
      end

      // ---- asynchronous reset while code 6 is presented ----
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 1'b0, 3'd0, 8'h00, 1'b0);
      req_n = 8'hFF;
      #2 rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         chk_all("after_rst", i, 1'b0, 3'd0, 8'h00, 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
